lifo_arbiter: RTL and testbench
===============================

# lifo_arbiter

Shares one `lifo` instance between NREQ requesters, each issuing push or pop operations. A round-robin arbiter issues at most one LIFO operation per cycle and never grants a push into a full stack or a pop from an empty one. Pop data is returned RD_LATENCY cycles later, tagged with the requester index. The block sits directly in front of the `lifo` and owns its `wrreq_i`, `rdreq_i` and `data_i` inputs.

## Interface
- DWIDTH, 16: data width; must match the `lifo`.
- NREQ, 4: number of requesters, 2..16.
- IDW, $clog2(NREQ): requester-index width.
- RD_LATENCY, 1: cycles from `lifo_rdreq_o` to valid `lifo_q_i`, ≥1.
- MAX_LOCK, 8: maximum consecutive grants to a locked owner (used only with the lock feature).

Ports (clock and reset first):
- clk_i  in  1  clock.
- arst_i  in  1  reset, asynchronous, active-high.
- req_i  in  NREQ  per-requester operation request.
- op_i  in  NREQ  per-requester operation: 0 = push, 1 = pop.
- wdata_i  in  NREQ*DWIDTH  push data; requester k occupies bits [k*DWIDTH +: DWIDTH].
- lock_i  in  NREQ  lock request; this port exists only with the lock feature.
- gnt_o  out  NREQ  one-hot grant; the operation is accepted in this cycle.
- rvalid_o  out  1  pop response valid.
- rid_o  out  IDW  index of the requester that issued the pop.
- rdata_o  out  DWIDTH  pop data.
- lifo_wrreq_o  out  1  connects to `lifo` wrreq_i.
- lifo_data_o  out  DWIDTH  connects to `lifo` data_i.
- lifo_rdreq_o  out  1  connects to `lifo` rdreq_i.
- lifo_q_i  in  DWIDTH  from `lifo` q_o.
- lifo_empty_i  in  1  from `lifo` empty_o.
- lifo_full_i  in  1  from `lifo` full_o.

## Operation
- Requester k is eligible when req_i[k] is high and:
  - for a push (op_i[k]=0), lifo_full_i is low;
  - for a pop (op_i[k]=1), lifo_empty_i is low.
- Ineligible requesters wait; their request is not dropped.
- Round-robin arbitration:
  - Search starts at pointer `prio`; the first eligible index at or after `prio`, wrapping at NREQ, wins.
  - After a grant, `prio` = winner+1, wrapping NREQ-1 → 0.
  - `prio` is unchanged in cycles with no grant.
- A grant drives the `lifo` combinationally in the same cycle:
  - lifo_wrreq_o = grant & push.
  - lifo_rdreq_o = grant & pop.
  - lifo_data_o = winner's wdata.
- Without a grant, both lifo_wrreq_o and lifo_rdreq_o are 0. Both are never high together.
- Flag consistency: the `lifo` flags reflect every operation issued in earlier cycles, so back-to-back operations are safe. For example, with one entry stored, a pop in cycle N makes lifo_empty_i high at N+1, which blocks pops at N+1.
- Response pipeline: a shift register of depth RD_LATENCY carries {valid, id}. rvalid_o/rid_o are the pipeline tail; rdata_o = lifo_q_i.
- With the lock feature, the FSM has two states, IDLE and LOCKED:
  - IDLE → LOCKED: on a grant to k with lock_i[k]=1. Owner := k; lock_cnt := 1.
  - In LOCKED, only the owner is eligible. Each owner grant increments lock_cnt.
  - LOCKED → IDLE when any of these holds:
    - an owner grant with lock_i low;
    - req_i[owner] is low;
    - lock_cnt reaches MAX_LOCK, after that grant.
  - On leaving LOCKED, `prio` = owner+1.
  - While LOCKED, if the owner is ineligible (full or empty), no grant is issued. The block does not fall back to other requesters.

## Timing
- Grant latency is 0 cycles: gnt_o rises in the same cycle as an eligible req_i.
- Pop data latency: rvalid_o is high exactly RD_LATENCY cycles after the gnt_o cycle.
- Throughput: one operation per cycle.
- Reset values while arst_i is high:
  - gnt_o = 0, lifo_wrreq_o = 0, lifo_rdreq_o = 0.
  - rvalid_o = 0, rid_o = 0.
  - prio = 0; FSM = IDLE; lock_cnt = 0.
- Reset asserted mid-operation:
  - In-flight pop responses are discarded; no rvalid_o appears after reset releases.
  - Any lock is cleared.
- rdata_o is undefined when rvalid_o is low.

## Configuration
- `LIFO_ARB_LOCK_EN` defined: the lock_i port, the IDLE/LOCKED FSM and lock_cnt are present.
- `LIFO_ARB_LOCK_EN` undefined: lock_i does not exist, and arbitration is pure round-robin on every cycle.

## Structure
- Package `lifo_arb_pkg` holds:
  - localparams OP_PUSH=1'b0 and OP_POP=1'b1;
  - typedef enum logic {ST_IDLE, ST_LOCKED} arb_state_t.
- Sub-module `rr_arbiter` (parameter N): takes an eligibility vector and a prio pointer, and outputs a one-hot grant plus the winner index. It is purely combinational; `lifo_arbiter` registers `prio`.

## Test plan
- Single pushes then pops (NREQ=4, RD_LATENCY=1): requester 2 pushes 0x1111, requester 0 pushes 0x2222, then requester 3 pops → rvalid_o one cycle later with rid_o=3 and rdata_o=0x2222.
- Round-robin fairness: all four requesters push continuously into an empty LIFO of depth 256 → gnt_o sequence 0,1,2,3,0,… with no cycle idle.
- Empty/full boundaries:
  - Pop with lifo_empty_i=1 → gnt_o=0 and no lifo_rdreq_o.
  - With one entry stored, two requesters pop → exactly one grant, and the second is blocked the next cycle.
  - Push at full → no grant.
- Lock (macro defined, MAX_LOCK=3): requester 1 holds lock_i and req_i with other requests pending → exactly 3 consecutive grants to 1, then a grant to 2.
- Reset during traffic: assert arst_i the cycle after a pop grant with RD_LATENCY=2 → no rvalid_o after release, and the first post-reset grant goes to requester 0.

Source files
------------

// File: rtl/lifo_arb_pkg.sv
// Shared definitions for the lifo_arbiter slice: operation encodings, lock FSM states
// and a small wrap-around index helper.
package lifo_arb_pkg;

    localparam logic OP_PUSH = 1'b0;
    localparam logic OP_POP  = 1'b1;

    typedef enum logic {ST_IDLE, ST_LOCKED} arb_state_t;

    // Next index after idx in a ring of n entries.
    function automatic int wrap_inc(input int idx, input int n);
        return (idx >= n - 1) ? 0 : idx + 1;
    endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin picker: first eligible index at or after prio, wrapping at N.
// Produces a one-hot grant, the winner index and a valid flag.
module rr_arbiter #(
    parameter int N  = 4,
    parameter int IW = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0]  elig,
    input  logic [IW-1:0] prio,
    output logic [N-1:0]  gnt,
    output logic [IW-1:0] idx,
    output logic          valid
);

    function automatic logic [IW-1:0] offset_idx(input logic [IW-1:0] base, input int off);
        int sum;
        sum = int'(base) + off;
        if (sum >= N) begin
            sum = sum - N;
        end
        return IW'(sum);
    endfunction

    logic [IW-1:0] cand;

    always_comb begin
        cand  = '0;
        idx   = '0;
        valid = 1'b0;
        for (int i = 0; i < N; i++) begin
            cand = offset_idx(prio, i);
            if (!valid && elig[cand]) begin
                valid = 1'b1;
                idx   = cand;
            end
        end
        gnt      = '0;
        gnt[idx] = valid;
    end

endmodule

// File: rtl/lifo_arbiter.sv
// lifo_arbiter: shares one lifo among NREQ push/pop requesters with round-robin grants and
// a tagged pop-response pipeline. Define LIFO_ARB_LOCK_EN to add lock_i and the lock FSM.
module lifo_arbiter
    import lifo_arb_pkg::*;
#(
    parameter int DWIDTH     = 16,
    parameter int NREQ       = 4,
    parameter int IDW        = $clog2(NREQ),
    parameter int RD_LATENCY = 1,
    parameter int MAX_LOCK   = 8
) (
    input  logic                   clk_i,
    input  logic                   arst_i,
    input  logic [NREQ-1:0]        req_i,
    input  logic [NREQ-1:0]        op_i,
    input  logic [NREQ*DWIDTH-1:0] wdata_i,
`ifdef LIFO_ARB_LOCK_EN
    input  logic [NREQ-1:0]        lock_i,
`endif
    output logic [NREQ-1:0]        gnt_o,
    output logic                   rvalid_o,
    output logic [IDW-1:0]         rid_o,
    output logic [DWIDTH-1:0]      rdata_o,
    output logic                   lifo_wrreq_o,
    output logic [DWIDTH-1:0]      lifo_data_o,
    output logic                   lifo_rdreq_o,
    input  logic [DWIDTH-1:0]      lifo_q_i,
    input  logic                   lifo_empty_i,
    input  logic                   lifo_full_i
);

    if (NREQ < 2 || RD_LATENCY < 1 || MAX_LOCK < 1) begin : g_bad_params
        $error("lifo_arbiter: unsupported parameter set");
    end

    logic [NREQ-1:0] elig_raw;
    logic [NREQ-1:0] elig;
    logic [NREQ-1:0] win_gnt;
    logic [IDW-1:0]  win_idx;
    logic            win_valid;
    logic            grant;
    logic            win_pop;
    logic [IDW-1:0]  prio_reg;
    logic [IDW-1:0]  prio_next;

    // A request waits (is simply not eligible) while the stack cannot serve its operation.
    for (genvar gi = 0; gi < NREQ; gi++) begin : g_elig
        assign elig_raw[gi] = req_i[gi] &&
                              ((op_i[gi] == OP_POP) ? !lifo_empty_i : !lifo_full_i);
    end

`ifdef LIFO_ARB_LOCK_EN
    localparam int LCW = $clog2(MAX_LOCK + 1);

    arb_state_t     state_reg, state_next;
    logic [IDW-1:0] owner_reg, owner_next;
    logic [LCW-1:0] lock_cnt_reg, lock_cnt_next;
    logic           lock_release;

    assign elig = (state_reg == ST_LOCKED) ? (elig_raw & (NREQ'(1) << owner_reg)) : elig_raw;

    always_ff @(posedge clk_i or posedge arst_i) begin
        if (arst_i) begin
            state_reg    <= ST_IDLE;
            owner_reg    <= '0;
            lock_cnt_reg <= '0;
        end else begin
            state_reg    <= state_next;
            owner_reg    <= owner_next;
            lock_cnt_reg <= lock_cnt_next;
        end
    end

    always_comb begin
        state_next    = state_reg;
        owner_next    = owner_reg;
        lock_cnt_next = lock_cnt_reg;
        lock_release  = 1'b0;
        unique case (state_reg)
            ST_IDLE: begin
                // A one-grant limit means the lock would end on the grant that takes it.
                if (grant && lock_i[win_idx] && (MAX_LOCK > 1)) begin
                    state_next    = ST_LOCKED;
                    owner_next    = win_idx;
                    lock_cnt_next = LCW'(1);
                end
            end
            ST_LOCKED: begin
                if (grant) begin
                    lock_cnt_next = lock_cnt_reg + 1'b1;
                    lock_release  = !lock_i[owner_reg] ||
                                    (lock_cnt_reg >= LCW'(MAX_LOCK - 1));
                end else begin
                    lock_release  = !req_i[owner_reg];
                end
                if (lock_release) begin
                    state_next    = ST_IDLE;
                    lock_cnt_next = '0;
                end
            end
            default: state_next = ST_IDLE;
        endcase
    end
`else
    assign elig = elig_raw;
`endif

    rr_arbiter #(
        .N  (NREQ),
        .IW (IDW)
    ) u_rr_arbiter (
        .elig  (elig),
        .prio  (prio_reg),
        .gnt   (win_gnt),
        .idx   (win_idx),
        .valid (win_valid)
    );

    // Outputs are forced quiet while reset is held, even though they are combinational.
    assign grant        = win_valid && !arst_i;
    assign win_pop      = (op_i[win_idx] == OP_POP);
    assign gnt_o        = grant ? win_gnt : '0;
    assign lifo_wrreq_o = grant && !win_pop;
    assign lifo_rdreq_o = grant && win_pop;
    assign lifo_data_o  = wdata_i[win_idx*DWIDTH +: DWIDTH];

    always_comb begin
        prio_next = prio_reg;
        if (grant) begin
            prio_next = IDW'(wrap_inc(int'(win_idx), NREQ));
        end
`ifdef LIFO_ARB_LOCK_EN
        else if (lock_release) begin
            prio_next = IDW'(wrap_inc(int'(owner_reg), NREQ));
        end
`endif
    end

    always_ff @(posedge clk_i or posedge arst_i) begin
        if (arst_i) begin
            prio_reg <= '0;
        end else begin
            prio_reg <= prio_next;
        end
    end

    // Response tag pipeline aligned with the lifo read latency; reset drops in-flight pops.
    logic [RD_LATENCY-1:0] vld_reg;
    logic [IDW-1:0]        rid_reg [RD_LATENCY];

    always_ff @(posedge clk_i or posedge arst_i) begin
        if (arst_i) begin
            vld_reg <= '0;
            for (int i = 0; i < RD_LATENCY; i++) begin
                rid_reg[i] <= '0;
            end
        end else begin
            for (int i = RD_LATENCY - 1; i > 0; i--) begin
                vld_reg[i] <= vld_reg[i-1];
                rid_reg[i] <= rid_reg[i-1];
            end
            vld_reg[0] <= lifo_rdreq_o;
            rid_reg[0] <= win_idx;
        end
    end

    assign rvalid_o = vld_reg[RD_LATENCY-1];
    assign rid_o    = rid_reg[RD_LATENCY-1];
    assign rdata_o  = lifo_q_i;

endmodule

// File: tb/tb_lifo_arbiter.sv
// Scoreboard bench for lifo_arbiter: a behavioural lifo drives the flags, a queue-based
// reference predicts grants and pop responses, and a monitor checks every rvalid_o.
module tb_lifo_arbiter;
    localparam int DW = 16, NR = 4, IW = 2, RDL = 2, ML = 3, DEPTH = 16;

    logic            clk = 1'b0;
    logic            rst = 1'b1;
    logic [NR-1:0]   req = '0;
    logic [NR-1:0]   op = '0;
    logic [NR*DW-1:0] wdata = '0;
`ifdef LIFO_ARB_LOCK_EN
    logic [NR-1:0]   lock = '0;
`endif
    logic [NR-1:0]   gnt;
    logic            rvalid;
    logic [IW-1:0]   rid;
    logic [DW-1:0]   rdata;
    logic            lifo_wrreq, lifo_rdreq, lifo_empty, lifo_full;
    logic [DW-1:0]   lifo_data, lifo_q;

    lifo_arbiter #(.DWIDTH(DW), .NREQ(NR), .IDW(IW), .RD_LATENCY(RDL), .MAX_LOCK(ML)) dut (
        .clk_i(clk), .arst_i(rst), .req_i(req), .op_i(op), .wdata_i(wdata),
`ifdef LIFO_ARB_LOCK_EN
        .lock_i(lock),
`endif
        .gnt_o(gnt), .rvalid_o(rvalid), .rid_o(rid), .rdata_o(rdata),
        .lifo_wrreq_o(lifo_wrreq), .lifo_data_o(lifo_data), .lifo_rdreq_o(lifo_rdreq),
        .lifo_q_i(lifo_q), .lifo_empty_i(lifo_empty), .lifo_full_i(lifo_full));

    always #5 clk = ~clk;

    // Environment: the lifo the arbiter fronts, with RDL-cycle read data.
    logic [DW-1:0] mem [DEPTH];
    logic [DW-1:0] qpipe [RDL];
    int env_cnt = 0;
    always @(posedge clk or posedge rst) begin
        if (rst) env_cnt <= 0;
        else if (lifo_wrreq && env_cnt < DEPTH) begin
            mem[env_cnt] <= lifo_data;
            env_cnt <= env_cnt + 1;
        end else if (lifo_rdreq && env_cnt > 0) env_cnt <= env_cnt - 1;
    end
    always @(posedge clk) begin
        for (int i = RDL - 1; i > 0; i--) qpipe[i] <= qpipe[i-1];
        qpipe[0] <= (lifo_rdreq && env_cnt > 0) ? mem[env_cnt-1] : '0;
    end
    assign lifo_empty = (env_cnt == 0);
    assign lifo_full  = (env_cnt == DEPTH);
    assign lifo_q     = qpipe[RDL-1];

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct { int id; logic [DW-1:0] data; int due; } rsp_t;
    rsp_t exp_q[$];
    logic [DW-1:0] ref_stack[$];
    int ref_prio = 0;
    bit use_ref = 1'b1;
    int checks = 0, failures = 0;
    logic [NR-1:0] last_gnt;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // One clock: predict from the round-robin rule, compare, then advance the reference.
    task automatic step();
        int w;
        logic [NR-1:0] eg;
        @(negedge clk);
        last_gnt = gnt;
        if (use_ref && !rst) begin
            w = -1;
            for (int i = 0; i < NR; i++) begin
                int k;
                bit ok;
                k  = (ref_prio + i) % NR;
                ok = req[k] && (op[k] ? (ref_stack.size() > 0) : (ref_stack.size() < DEPTH));
                if (ok && w < 0) w = k;
            end
            eg = (w >= 0) ? (NR'(1) << w) : '0;
            check("gnt", gnt, eg);
            check("wrreq", lifo_wrreq, (w >= 0) && !op[w]);
            check("rdreq", lifo_rdreq, (w >= 0) && op[w]);
            if (w >= 0) begin
                if (!op[w]) begin
                    check("lifo_data", lifo_data, wdata[w*DW +: DW]);
                    ref_stack.push_back(wdata[w*DW +: DW]);
                end else begin
                    rsp_t r;
                    r.id = w;
                    r.data = ref_stack.pop_back();
                    r.due = cyc + RDL;
                    exp_q.push_back(r);
                end
                ref_prio = (w + 1) % NR;
            end
            $display("cyc=%0d req=%b op=%b gnt=%b exp=%b depth=%0d", cyc, req, op, gnt, eg, ref_stack.size());
        end
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        ref_stack.delete();
        exp_q.delete();
        ref_prio = 0;
        @(posedge clk);
        #1 rst = 1'b0;
    endtask

    // Monitor: every rvalid_o must match the oldest outstanding pop, on its due cycle.
    initial begin
        rsp_t r;
        forever begin
            @(negedge clk);
            if (exp_q.size() > 0 && exp_q[0].due <= cyc) begin
                r = exp_q.pop_front();
                check("rvalid", rvalid, 1'b1);
                check("rid", rid, r.id);
                check("rdata", rdata, r.data);
                $display("rsp cyc=%0d rid=%0d rdata=%h exp_rid=%0d exp_data=%h", cyc, rid, rdata, r.id, r.data);
            end else if (rvalid) begin
                check("rvalid_spurious", rvalid, 1'b0);
            end
        end
    end

    initial begin
        // Reset values with requests already asserted.
        req = '1; op = '0;
        @(negedge clk);
        check("rst_gnt", gnt, 0);
        check("rst_wrreq", lifo_wrreq, 0);
        check("rst_rdreq", lifo_rdreq, 0);
        check("rst_rvalid", rvalid, 0);
        check("rst_rid", rid, 0);
        req = '0;
        @(posedge clk);
        #1 rst = 1'b0;

        // Two pushes then a pop returning the most recent data to requester 3.
        req = 4'b0100; op = 4'b0000; wdata[2*DW +: DW] = 16'h1111; step();
        req = 4'b0001; wdata[0 +: DW] = 16'h2222; step();
        req = 4'b1000; op = 4'b1000; step();
        check("pop_gnt", last_gnt, 4'b1000);
        req = '0; op = '0;
        for (int i = 1; i < RDL; i++) step();
        @(negedge clk);
        check("pop_rvalid", rvalid, 1'b1);
        check("pop_rid", rid, 3);
        check("pop_rdata", rdata, 16'h2222);
        @(posedge clk); #1;

        // Drain the last entry, then popping an empty stack must not be granted.
        req = 4'b0010; op = 4'b0010; step();
        step();
        check("empty_pop_gnt", last_gnt, 0);

        // One entry, two poppers: one grant, the other blocked next cycle.
        req = 4'b0001; op = 4'b0000; wdata[0 +: DW] = 16'hABCD; step();
        req = 4'b0101; op = 4'b0101; step();
        check("one_entry_grants", $countones(last_gnt), 1);
        step();
        check("second_pop_blocked", last_gnt, 0);
        req = '0; op = '0; step(); step();

        // Fairness from reset: continuous pushes rotate 0,1,2,3 until full.
        do_reset();
        req = 4'b1111; op = 4'b0000;
        for (int i = 0; i < DEPTH; i++) begin
            wdata = {$urandom, $urandom};
            step();
            check("rr_order", last_gnt, NR'(1) << (i % NR));
        end
        step();
        check("full_push_gnt", last_gnt, 0);

        // Random traffic alternating push-heavy and pop-heavy phases.
        for (int i = 0; i < 600; i++) begin
            int pop_pct;
            pop_pct = ((i / 60) % 2 == 0) ? 25 : 75;
            req = NR'($urandom);
            for (int k = 0; k < NR; k++) op[k] = ($urandom_range(99) < pop_pct);
            wdata = {$urandom, $urandom};
            step();
        end
        req = '0; op = '0;
        for (int i = 0; i < RDL + 2; i++) step();

        // Reset the cycle after a pop grant: the response must vanish, prio restarts at 0.
        do_reset();
        req = 4'b0001; op = 4'b0000; wdata[0 +: DW] = 16'h5A5A; step();
        req = 4'b0010; op = 4'b0010; step();
        check("pre_rst_pop_gnt", last_gnt, 4'b0010);
        rst = 1'b1;
        ref_stack.delete();
        exp_q.delete();
        ref_prio = 0;
        req = 4'b1111; op = 4'b0000;
        step();
        check("mid_rst_gnt", last_gnt, 0);
        check("mid_rst_rvalid", rvalid, 0);
        rst = 1'b0;
        step();
        check("post_rst_first_gnt", last_gnt, 4'b0001);
        req = '0;
        for (int i = 0; i < RDL + 2; i++) step();

`ifdef LIFO_ARB_LOCK_EN
        // Lock: requester 1 gets exactly ML consecutive grants, then requester 2.
        do_reset();
        req = 4'b0001; op = '0; step();
        use_ref = 1'b0;
        req = 4'b1111; lock = 4'b0010;
        for (int i = 0; i < ML; i++) begin
            step();
            check("lock_owner_gnt", last_gnt, 4'b0010);
        end
        step();
        check("lock_release_gnt", last_gnt, 4'b0100);
        req = '0; lock = '0;
        step();
`endif

        check("scoreboard_drained", exp_q.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
